seg_display_sched: RTL and testbench

//   Frame-synchronous scheduler between the digit classifier and the 640x480 VGA digit renderer.

---
 rtl/seg_display_sched.sv | 156 +++++++++++++++
 tb/tb_seg_display_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_sched.sv
// rtl/seg_display_sched.sv - classifier scheduler with a shadow digit bank committed at vsync fall
module seg_display_sched #(
    parameter int NSEG    = 6,
    parameter int TIMEOUT = 4096
) (
    input  logic              dclk,
    input  logic              clr_n,
    input  logic              vsync,
    input  logic              start,
    input  logic              auto_run,
    output logic              cls_req,
    output logic [2:0]        cls_seg,
    input  logic              cls_valid,
    input  logic [3:0]        cls_digit,
    output logic [4*NSEG-1:0] disp_digits,
    output logic              busy,
    output logic              frame_done,
    output logic              err_timeout
);
    // Counter only needs to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_VB
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_idx;
    logic [CW-1:0]     r_cnt;
    logic              r_gap;
    logic              r_vsync_q;
    logic              r_frame_done;
    logic              r_err;
    logic [4*NSEG-1:0] r_shadow;
    logic [4*NSEG-1:0] r_disp;

    logic       w_req;
    logic       w_accept;
    logic       w_tmo;
    logic       w_adv;
    logic       w_last;
    logic       w_start;
    logic       w_commit;
    logic [3:0] w_result;

    // r_gap forces the one idle cycle between consecutive segment requests.
    assign w_req    = (r_state == S_REQ) && !r_gap;
    assign w_accept = w_req && cls_valid;
    // A valid result on the final cycle beats the timeout.
    assign w_tmo    = w_req && !cls_valid && (r_cnt == CW'(TIMEOUT - 1));
    assign w_adv    = w_accept || w_tmo;
    assign w_last   = (r_idx == 3'(NSEG - 1));
    assign w_start  = (r_state == S_IDLE) && start;
    // frame_done marks the cycle after a commit, so a second commit cannot follow it.
    assign w_commit = (r_state == S_WAIT_VB) && !vsync && r_vsync_q && !r_frame_done;
    assign w_result = (w_accept && (cls_digit <= 4'd9)) ? cls_digit : 4'hF;

    assign cls_req     = w_req;
    assign cls_seg     = r_idx;
    assign busy        = (r_state != S_IDLE);
    assign frame_done  = r_frame_done;
    assign err_timeout = r_err;
    assign disp_digits = r_disp;

    // State register.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: leave WAIT_VB only after the frame_done cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_REQ;
            S_REQ:     if (w_adv && w_last) w_next = S_WAIT_VB;
            S_WAIT_VB: if (r_frame_done) w_next = auto_run ? S_REQ : S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Segment index, per-request wait counter and inter-request gap.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_idx <= 3'd0;
            r_cnt <= '0;
            r_gap <= 1'b0;
        end else if (w_start) begin
            r_idx <= 3'd0;
            r_cnt <= '0;
            r_gap <= 1'b0;
        end else if (r_state == S_REQ) begin
            if (r_gap) begin
                r_gap <= 1'b0;
            end else if (w_adv) begin
                r_cnt <= '0;
                if (w_last) begin
                    r_idx <= 3'd0;
                end else begin
                    r_idx <= r_idx + 3'd1;
                    r_gap <= 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Shadow bank: record each segment's result (or blank) as it completes.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_shadow <= '1;
        end else if (w_adv) begin
            for (int i = 0; i < NSEG; i++) begin
                if (r_idx == 3'(i)) r_shadow[4*i +: 4] <= w_result;
            end
        end
    end

    // Display bank and frame_done update together on the vsync falling edge.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_disp       <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_commit;
            if (w_commit) r_disp <= r_shadow;
        end
    end

    // vsync history for falling-edge detection, tracked in every state.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_vsync_q <= 1'b1;
        end else begin
            r_vsync_q <= vsync;
        end
    end

    // Sticky timeout flag, cleared by an accepted start.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_err <= 1'b0;
        end else if (w_start) begin
            r_err <= 1'b0;
        end else if (w_tmo) begin
            r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seg_display_sched.sv
// tb/tb_seg_display_sched.sv - randomized self-checking bench for seg_display_sched
module tb_seg_display_sched;
    localparam int NSEG    = 6;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 99;

    logic              dclk = 1'b0;
    logic              clr_n = 1'b0;
    logic              vsync = 1'b1;
    logic              start = 1'b0;
    logic              auto_run = 1'b0;
    logic              cls_valid = 1'b0;
    logic [3:0]        cls_digit = 4'd0;
    logic              cls_req;
    logic [2:0]        cls_seg;
    logic [4*NSEG-1:0] disp_digits;
    logic              busy;
    logic              frame_done;
    logic              err_timeout;

    int                n_checks = 0;
    int                n_pass = 0;
    int                pd[NSEG];
    logic [3:0]        pg[NSEG];
    logic [4*NSEG-1:0] exp_disp = '1;
    logic              exp_err = 1'b0;
    logic              start_noise = 1'b0;

    seg_display_sched #(.NSEG(NSEG), .TIMEOUT(TIMEOUT)) dut (
        .dclk        (dclk),
        .clr_n       (clr_n),
        .vsync       (vsync),
        .start       (start),
        .auto_run    (auto_run),
        .cls_req     (cls_req),
        .cls_seg     (cls_seg),
        .cls_valid   (cls_valid),
        .cls_digit   (cls_digit),
        .disp_digits (disp_digits),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_timeout (err_timeout)
    );

    always #20 dclk = ~dclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    // Plan-level model: a segment shows its digit only if answered within the window with a legal value.
    function automatic logic [4*NSEG-1:0] model_disp();
        logic [4*NSEG-1:0] r;
        r = '1;
        for (int s = 0; s < NSEG; s++) begin
            if (pd[s] < TIMEOUT && pg[s] <= 4'd9) r[4*s +: 4] = pg[s];
        end
        return r;
    endfunction

    task automatic start_pass();
        exp_err = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("err_cleared", err_timeout, 0);
    endtask

    // Acts as the classifier: answers segment s pd[s] cycles after its request rises.
    task automatic run_segments(input bit pre_low);
        for (int s = 0; s < NSEG; s++) begin
            int n = 0;
            int k = 0;
            while (!cls_req && n < 8) begin
                cls_valid = 1'($urandom);
                cls_digit = 4'($urandom);
                tick();
                n++;
            end
            cls_valid = 1'b0;
            chk("req_gap", n, (s == 0) ? 0 : 1);
            chk("cls_seg", cls_seg, s);
            while (cls_req && k < TIMEOUT + 4) begin
                cls_valid = (k == pd[s]);
                cls_digit = (k == pd[s]) ? pg[s] : 4'($urandom);
                start = start_noise ? 1'($urandom) : 1'b0;
                if (pre_low && s == NSEG - 1) vsync = 1'b0;
                tick();
                k++;
            end
            cls_valid = 1'b0;
            start = 1'b0;
            if (pd[s] >= TIMEOUT) exp_err = 1'b1;
            chk("req_held", k, (pd[s] < TIMEOUT) ? pd[s] + 1 : TIMEOUT);
            chk("err_timeout", err_timeout, exp_err);
            chk("disp_stable", disp_digits, exp_disp);
        end
    endtask

    task automatic do_commit(input bit pre_low, input bit autorun);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("disp_before_vs", disp_digits, exp_disp);
            chk("fd_before_vs", frame_done, 0);
        end
        chk("busy_wait_vb", busy, 1);
        if (pre_low) begin
            vsync = 1'b1;
            tick();
            tick();
            chk("disp_low_entry", disp_digits, exp_disp);
            chk("fd_low_entry", frame_done, 0);
        end
        start = start_noise;
        tick();
        start = 1'b0;
        vsync = 1'b0;
        tick();
        exp_disp = model_disp();
        chk("disp_commit", disp_digits, exp_disp);
        chk("fd_pulse", frame_done, 1);
        tick();
        chk("fd_once", frame_done, 0);
        if (autorun) begin
            chk("auto_req", cls_req, 1);
            chk("auto_seg", cls_seg, 0);
        end else begin
            chk("idle_after", busy, 0);
        end
        vsync = 1'b1;
    endtask

    task automatic random_plan();
        for (int s = 0; s < NSEG; s++) begin
            pd[s] = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, 6));
            pg[s] = 4'($urandom);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_req", cls_req, 0);
        chk("rst_seg", cls_seg, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_disp", disp_digits, 24'hFFFFFF);
        clr_n = 1'b1;
        tick();

        // Normal pass: digits 1..6, each after 3 cycles.
        for (int s = 0; s < NSEG; s++) begin
            pd[s] = 3;
            pg[s] = 4'(s + 1);
        end
        start_pass();
        run_segments(1'b0);
        do_commit(1'b0, 1'b0);
        chk("normal_value", disp_digits, 24'h654321);

        // Segment 2 never answers.
        random_plan();
        for (int s = 0; s < NSEG; s++) pg[s] = 4'($urandom_range(0, 9));
        pd[2] = NEVER;
        start_pass();
        run_segments(1'b0);
        do_commit(1'b0, 1'b0);
        chk("timeout_err", err_timeout, 1);

        // Illegal digit on segment 0, no timeouts.
        for (int s = 0; s < NSEG; s++) begin
            pd[s] = $urandom_range(0, 4);
            pg[s] = 4'($urandom_range(0, 9));
        end
        pg[0] = 4'hC;
        start_pass();
        run_segments(1'b0);
        do_commit(1'b0, 1'b0);
        chk("illegal_no_err", err_timeout, 0);

        // start pulses while busy, vsync already low on entry to WAIT_VB.
        random_plan();
        start_noise = 1'b1;
        start_pass();
        run_segments(1'b1);
        do_commit(1'b1, 1'b0);
        start_noise = 1'b0;

        // Valid on the timeout edge, then an auto_run second pass.
        for (int s = 0; s < NSEG; s++) begin
            pd[s] = $urandom_range(0, 3);
            pg[s] = 4'($urandom_range(0, 9));
        end
        pd[1] = TIMEOUT - 1;
        auto_run = 1'b1;
        start_pass();
        run_segments(1'b0);
        do_commit(1'b0, 1'b1);
        chk("same_edge_no_err", err_timeout, 0);
        auto_run = 1'b0;
        random_plan();
        run_segments(1'b0);
        do_commit(1'b0, 1'b0);

        // Randomized passes.
        for (int p = 0; p < 4; p++) begin
            bit pl;
            random_plan();
            pl = 1'($urandom);
            start_noise = 1'($urandom);
            start_pass();
            run_segments(pl);
            do_commit(pl, 1'b0);
        end
        start_noise = 1'b0;

        // Reset mid-REQ after a timeout has been flagged.
        for (int s = 0; s < NSEG; s++) begin
            pd[s] = 2;
            pg[s] = 4'd7;
        end
        pd[0] = NEVER;
        start_pass();
        for (int i = 0; i < 40 && !(err_timeout && cls_req); i++) tick();
        chk("pre_rst_err", err_timeout, 1);
        chk("pre_rst_req", cls_req, 1);
        clr_n = 1'b0;
        #2;
        chk("mid_rst_req", cls_req, 0);
        chk("mid_rst_seg", cls_seg, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_fd", frame_done, 0);
        chk("mid_rst_err", err_timeout, 0);
        chk("mid_rst_disp", disp_digits, 24'hFFFFFF);
        tick();
        clr_n = 1'b1;
        tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_req", cls_req, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
